// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for a multi-cycle MIPS datapath (shared ALU, single memory,
//   PC/IR/MDR/A/B/ALUOut registers). Sequences R-type, lw, sw, beq, j, addi, andi,
//   ori and slti. Memory accesses (FETCH, MEMRD, MEMWR) each take MEM_LAT cycles.
//   Unsupported opcodes set a sticky illegal flag; fetching continues.
//
// Parameters
//   MEM_LAT  cycles per memory access (>=1)
//   ALUOP_W  ALUOp width (010 R-funct, 011 add, 100 sub, 111 and, 101 or, 001 slt)
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   OPCODE[5:0]             IR[31:26], stable from DECODE to end of instruction
//   PCWrite, PCWriteCond    PC load (unconditional / on ALU Zero)
//   IorD                    memory address select 0=PC 1=ALUOut
//   MemRead, MemWrite       memory strobes
//   IRWrite                 instruction register load
//   MemToReg, RegDst        register write data / destination select
//   RegWrite                register file write
//   ALUSrcA, ALUSrcB[1:0]   ALU operand selects
//   ALUOp[ALUOP_W-1:0]      ALU operation class
//   PCSource[1:0]           PC input select 00=ALU 01=ALUOut 10=jump target
//   instr_done              pulse in the last state of each instruction
//   illegal                 sticky unsupported-opcode flag
//   state[3:0]              current state (debug)
//
// state  | meaning
// IDLE   | after reset, leaves on the first clock
// FETCH  | read instruction, PC+4 (MEM_LAT cycles, IR/PC load in last)
// DECODE | register read, branch target into ALUOut, dispatch on OPCODE
// MEMADR | compute lw/sw address
// MEMRD  | data read (MEM_LAT cycles)
// MEMWB  | write MDR to rt
// MEMWR  | data write (MEM_LAT cycles, strobe in last)
// EXEC   | R-type ALU operation
// ALUWB  | write ALUOut to rd
// BRANCH | beq compare and conditional PC load
// JUMP   | PC load from jump target
// IEXEC  | immediate ALU operation
// IWB    | write ALUOut to rt

module multicycle_control #(
  parameter int MEM_LAT = 1,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         OPCODE,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal,
  output logic [3:0]         state
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  localparam logic [ALUOP_W-1:0] OP_RFN = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(3'b111);
  localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] OP_SLT = ALUOP_W'(3'b001);

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_ANDI = 6'b001100;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_SLTI = 6'b001010;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    IEXEC  = 4'd11,
    IWB    = 4'd12
  } state_t;

  state_t           cur, nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             last_wait;
  logic             set_illegal;

  assign in_wait   = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
  assign last_wait = (wait_cnt == CNT_LAST);
  assign state     = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= IDLE;
      wait_cnt <= '0;
      illegal  <= 1'b0;
    end else begin
      cur <= nxt;
      // Counter only advances inside a wait state; it is zero whenever one is entered.
      if (in_wait && !last_wait) wait_cnt <= wait_cnt + CNT_W'(1);
      else                       wait_cnt <= '0;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    nxt         = cur;
    set_illegal = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = '0;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    case (cur)
      IDLE: nxt = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = OP_ADD;
        if (last_wait) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = OP_ADD;
        case (OPCODE)
          OPC_R:                                  nxt = EXEC;
          OPC_LW, OPC_SW:                         nxt = MEMADR;
          OPC_BEQ:                                nxt = BRANCH;
          OPC_J:                                  nxt = JUMP;
          OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_SLTI:  nxt = IEXEC;
          default: begin
            set_illegal = 1'b1;
            instr_done  = 1'b1;
            nxt         = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = OP_ADD;
        nxt     = (OPCODE == OPC_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (last_wait) nxt = MEMWB;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MEMWR: begin
        IorD = 1'b1;
        if (last_wait) begin
          MemWrite   = 1'b1;
          instr_done = 1'b1;
          nxt        = FETCH;
        end
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = OP_RFN;
        nxt     = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = OP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
        nxt         = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OPCODE)
          OPC_ANDI: ALUOp = OP_AND;
          OPC_ORI:  ALUOp = OP_OR;
          OPC_SLTI: ALUOp = OP_SLT;
          default:  ALUOp = OP_ADD;
        endcase
        nxt = IWB;
      end
      IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
